// File: rtl/play_rate_dsp.sv
// Playback-rate stage between the SRAM controller and the I2S transmitter.
// Each I2S request yields exactly one output sample. Fast speeds decimate by
// fetching N samples and keeping the last one. Slow speeds stretch the signal
// by zero-order hold or by linear interpolation through a serial divider.
module play_rate_dsp (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [2:0]  i_state,
   input  logic [3:0]  i_play_speed,
   input  logic        i_slot_way,
   input  logic        i_I2S_request,
   output logic        o_request_data,
   input  logic        i_data_valid,
   input  logic [15:0] i_data,
   output logic [15:0] o_data,
   output logic        o_valid
);

   localparam logic [2:0] PLAY_PLAY  = 3'b010;
   localparam logic [2:0] PLAY_PAUSE = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_DIV,
      ST_OUT
   } fsm_t;

   fsm_t               fsm;

   // sample history, phase and latched speed
   logic signed [15:0] prev;
   logic signed [15:0] cur;
   logic [2:0]         k;
   logic [3:0]         spd;

   // sequencing and divider state
   logic [2:0]         fetch_left;
   logic               use_div;
   logic [20:0]        div_q;
   logic [3:0]         div_rem;
   logic [4:0]         div_cnt;
   logic               div_neg;

   // acceptance-time decode of the incoming speed code
   logic               acc_fast;
   logic               acc_slow;
   logic [3:0]         acc_div;
   logic [2:0]         acc_k;
   logic [3:0]         wgt_prev;

   // interpolation numerator
   logic signed [20:0] prev_x;
   logic signed [20:0] cur_x;
   logic signed [20:0] w_prev_x;
   logic signed [20:0] w_cur_x;
   logic signed [20:0] num;
   logic [20:0]        num_mag;

   // run-time decode of the latched speed code and divider step
   logic               spd_slow;
   logic [3:0]         spd_div;
   logic [2:0]         k_next;
   logic [4:0]         trial;
   logic               ge;
   logic [3:0]         rem_next;
   logic [15:0]        quot_lo;
   logic [15:0]        quot;

   // Decode the request-time speed, form the interpolation numerator and the
   // next divider step; all purely combinational.
   always_comb begin
      acc_fast = i_play_speed[3] && (i_play_speed[2:0] != 3'd0);
      acc_slow = !i_play_speed[3] && (i_play_speed[2:0] != 3'd0);
      acc_div  = {1'b0, i_play_speed[2:0]} + 4'd1;
      acc_k    = (i_play_speed != spd) ? 3'd0 : k;
      wgt_prev = acc_div - {1'b0, acc_k};

      prev_x   = {{5{prev[15]}}, prev};
      cur_x    = {{5{cur[15]}}, cur};
      w_prev_x = {17'd0, wgt_prev};
      w_cur_x  = {18'd0, acc_k};
      num      = (prev_x * w_prev_x) + (cur_x * w_cur_x);
      num_mag  = num[20] ? (~num + 21'd1) : num;

      spd_slow = !spd[3] && (spd[2:0] != 3'd0);
      spd_div  = {1'b0, spd[2:0]} + 4'd1;
      k_next   = (k == spd[2:0]) ? 3'd0 : (k + 3'd1);

      // restoring step: bring down the next dividend bit, subtract if it fits
      trial    = {div_rem, div_q[20]};
      ge       = (trial >= {1'b0, spd_div});
      rem_next = ge ? (trial[3:0] - spd_div) : trial[3:0];

      quot_lo  = div_q[15:0];
      quot     = div_neg ? (~quot_lo + 16'd1) : quot_lo;
   end

   // Request sequencer, history update and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         fsm            <= ST_IDLE;
         prev           <= '0;
         cur            <= '0;
         k              <= '0;
         spd            <= '0;
         fetch_left     <= '0;
         use_div        <= 1'b0;
         div_q          <= '0;
         div_rem        <= '0;
         div_cnt        <= '0;
         div_neg        <= 1'b0;
         o_data         <= '0;
         o_valid        <= 1'b0;
         o_request_data <= 1'b0;
      end else if (i_state != PLAY_PLAY) begin
         // any in-flight operation is dropped; pause keeps the history
         fsm            <= ST_IDLE;
         o_valid        <= 1'b0;
         o_request_data <= 1'b0;
         if (i_state != PLAY_PAUSE) begin
            prev <= '0;
            cur  <= '0;
            k    <= '0;
            spd  <= '0;
         end
      end else begin
         o_valid        <= 1'b0;
         o_request_data <= 1'b0;
         case (fsm)
            ST_IDLE: begin
               if (i_I2S_request) begin
                  spd <= i_play_speed;
                  k   <= acc_k;
                  if (acc_slow && (acc_k != 3'd0)) begin
                     if (i_slot_way) begin
                        use_div <= 1'b0;
                        fsm     <= ST_OUT;
                     end else begin
                        use_div <= 1'b1;
                        div_q   <= num_mag;
                        div_neg <= num[20];
                        div_rem <= '0;
                        div_cnt <= '0;
                        fsm     <= ST_DIV;
                     end
                  end else begin
                     fetch_left     <= acc_fast ? i_play_speed[2:0] : 3'd0;
                     o_request_data <= 1'b1;
                     fsm            <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               fsm <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_data_valid) begin
                  prev <= cur;
                  cur  <= i_data;
                  if (fetch_left != 3'd0) begin
                     fetch_left     <= fetch_left - 3'd1;
                     o_request_data <= 1'b1;
                     fsm            <= ST_FETCH;
                  end else begin
                     o_valid <= 1'b1;
                     fsm     <= ST_IDLE;
                     if (spd_slow) begin
                        // slow k==0 emits the sample that just became prev
                        o_data <= cur;
                        k      <= k_next;
                     end else begin
                        o_data <= i_data;
                     end
                  end
               end
            end
            ST_DIV: begin
               // dividend shifts out the top while quotient bits shift in below
               div_q   <= {div_q[19:0], ge};
               div_rem <= rem_next;
               div_cnt <= div_cnt + 5'd1;
               if (div_cnt == 5'd20) begin
                  fsm <= ST_OUT;
               end
            end
            ST_OUT: begin
               o_valid <= 1'b1;
               o_data  <= use_div ? quot : prev;
               k       <= k_next;
               fsm     <= ST_IDLE;
            end
            default: begin
               fsm <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_play_rate_dsp.sv
// Self-checking bench for play_rate_dsp: an SRAM responder feeds queued
// samples, a monitor pops expected outputs from a scoreboard queue.
module tb_play_rate_dsp;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [2:0]  i_state;
   logic [3:0]  i_play_speed;
   logic        i_slot_way;
   logic        i_I2S_request;
   logic        o_request_data;
   logic        i_data_valid;
   logic [15:0] i_data;
   logic [15:0] o_data;
   logic        o_valid;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          req_cnt = 0;
   int          out_cnt = 0;
   int          valid_cyc = 0;
   int          out_cyc = 0;
   bit          sram_auto = 1'b1;
   bit          drove = 1'b0;
   logic [15:0] src_q[$];
   logic [15:0] exp_q[$];

   play_rate_dsp dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_state        (i_state),
      .i_play_speed   (i_play_speed),
      .i_slot_way     (i_slot_way),
      .i_I2S_request  (i_I2S_request),
      .o_request_data (o_request_data),
      .i_data_valid   (i_data_valid),
      .i_data         (i_data),
      .o_data         (o_data),
      .o_valid        (o_valid)
   );

   initial forever #5 i_clk = ~i_clk;

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   // SRAM model: answers each fetch pulse one cycle later with the next sample
   initial begin
      i_data_valid = 1'b0;
      i_data       = '0;
      forever begin
         @(negedge i_clk);
         if (drove) begin
            i_data_valid = 1'b0;
            drove        = 1'b0;
         end
         if (o_request_data) begin
            req_cnt++;
            if (sram_auto && src_q.size() > 0) begin
               @(negedge i_clk);
               i_data       = src_q.pop_front();
               i_data_valid = 1'b1;
               valid_cyc    = cyc;
               drove        = 1'b1;
            end
         end
      end
   end

   // output monitor and scoreboard
   initial forever begin
      logic [15:0] e;
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) begin
         out_cnt++;
         out_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: o_data=%0d with nothing expected", $signed(o_data));
         end else begin
            e = exp_q.pop_front();
            if (o_data !== e) begin
               errors++;
               $display("FAIL out_data: got %0d expected %0d", $signed(o_data), $signed(e));
            end
         end
         checks++;
         if (o_request_data !== 1'b0) begin
            errors++;
            $display("FAIL valid_req_overlap: o_request_data=%b expected 0", o_request_data);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   task automatic push_src(input int v);
      src_q.push_back(16'(v));
   endtask

   task automatic clear_history();
      @(negedge i_clk);
      i_state = 3'b000;
      repeat (2) @(negedge i_clk);
      i_state = 3'b010;
      src_q.delete();
   endtask

   // lat_kind: 0 none, 1 one cycle after i_data_valid, 2 two cycles after
   // the request, 3 at most 24 cycles after the request
   task automatic do_req(input string name, input logic [3:0] sp, input logic hold,
                         input int exp_data, input int exp_fetch, input int lat_kind);
      int r0;
      int o0;
      int n;
      int rc;
      exp_q.push_back(16'(exp_data));
      r0 = req_cnt;
      o0 = out_cnt;
      @(negedge i_clk);
      i_play_speed  = sp;
      i_slot_way    = hold;
      i_I2S_request = 1'b1;
      rc = cyc;
      @(negedge i_clk);
      i_I2S_request = 1'b0;
      i_play_speed  = sp ^ 4'b0110;
      i_slot_way    = ~hold;
      n = 0;
      while (out_cnt == o0 && n < 60) begin
         @(negedge i_clk);
         n++;
      end
      checks++;
      if (out_cnt == o0) begin
         errors++;
         $display("FAIL %s_timeout: no o_valid within 60 cycles, expected data %0d", name, exp_data);
         exp_q.delete();
      end else begin
         checks++;
         if (req_cnt - r0 != exp_fetch) begin
            errors++;
            $display("FAIL %s_fetches: got %0d expected %0d", name, req_cnt - r0, exp_fetch);
         end
         if (lat_kind == 1) begin
            checks++;
            if (out_cyc - valid_cyc != 1) begin
               errors++;
               $display("FAIL %s_latency: got %0d cycles after data_valid expected 1", name, out_cyc - valid_cyc);
            end
         end else if (lat_kind == 2) begin
            checks++;
            if (out_cyc - rc != 2) begin
               errors++;
               $display("FAIL %s_latency: got %0d cycles after request expected 2", name, out_cyc - rc);
            end
         end else if (lat_kind == 3) begin
            checks++;
            if (out_cyc - rc > 24) begin
               errors++;
               $display("FAIL %s_latency: got %0d cycles after request expected <=24", name, out_cyc - rc);
            end
         end
      end
      @(negedge i_clk);
   endtask

   task automatic pulse_request(input logic [3:0] sp, input logic hold);
      @(negedge i_clk);
      i_play_speed  = sp;
      i_slot_way    = hold;
      i_I2S_request = 1'b1;
      @(negedge i_clk);
      i_I2S_request = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b0;
      i_state = 3'b000;
      i_play_speed = 4'd0;
      i_slot_way = 1'b0;
      i_I2S_request = 1'b0;
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_data !== 16'd0 || o_valid !== 1'b0 || o_request_data !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: data=%0d valid=%b req=%b expected 0 0 0", o_data, o_valid, o_request_data);
      end
      i_rst = 1'b1;
      @(negedge i_clk);
      i_state = 3'b010;
   endtask

   task automatic test_x1();
      clear_history();
      push_src(100); push_src(200); push_src(300); push_src(5);
      do_req("x1_a", 4'b0000, 1'b0, 100, 1, 1);
      do_req("x1_b", 4'b0000, 1'b0, 200, 1, 1);
      do_req("x1_c", 4'b0000, 1'b0, 300, 1, 1);
      do_req("x1_reserved", 4'b1000, 1'b0, 5, 1, 1);
   endtask

   task automatic test_fast();
      clear_history();
      for (int i = 1; i <= 8; i++) push_src(i);
      do_req("x4_a", 4'b1011, 1'b0, 4, 4, 1);
      do_req("x4_b", 4'b1011, 1'b0, 8, 4, 1);
      for (int i = 11; i <= 18; i++) push_src(i);
      do_req("x8", 4'b1111, 1'b0, 18, 8, 1);
      push_src(21); push_src(22);
      do_req("x2", 4'b1001, 1'b0, 22, 2, 1);
   endtask

   task automatic test_slow_interp();
      int exp_d[8] = '{0, 0, 0, 0, 0, 100, 200, 300};
      int exp_f[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
      clear_history();
      push_src(0); push_src(400);
      for (int i = 0; i < 8; i++)
         do_req("interp4", 4'b0011, 1'b0, exp_d[i], exp_f[i], (exp_f[i] == 1) ? 1 : 3);
      clear_history();
      push_src(-7); push_src(0);
      do_req("neg_a", 4'b0001, 1'b0, 0, 1, 1);
      do_req("neg_b", 4'b0001, 1'b0, -3, 0, 3);
      do_req("neg_c", 4'b0001, 1'b0, -7, 1, 1);
      do_req("neg_d", 4'b0001, 1'b0, -3, 0, 3);
   endtask

   task automatic test_slow_hold();
      int exp_d[6] = '{0, 0, 0, 50, 50, 50};
      int exp_f[6] = '{1, 0, 0, 1, 0, 0};
      clear_history();
      push_src(50); push_src(60);
      for (int i = 0; i < 6; i++)
         do_req("hold3", 4'b0010, 1'b1, exp_d[i], exp_f[i], (exp_f[i] == 1) ? 1 : 2);
   endtask

   task automatic test_pause_stop();
      int r0;
      int o0;
      clear_history();
      push_src(400);
      do_req("pause_k0", 4'b0011, 1'b0, 0, 1, 1);
      do_req("pause_k1", 4'b0011, 1'b0, 100, 0, 3);
      @(negedge i_clk);
      i_state = 3'b011;
      r0 = req_cnt;
      o0 = out_cnt;
      pulse_request(4'b0011, 1'b0);
      repeat (30) @(negedge i_clk);
      checks++;
      if (out_cnt != o0 || req_cnt != r0) begin
         errors++;
         $display("FAIL paused_activity: outputs=%0d fetches=%0d expected 0 0", out_cnt - o0, req_cnt - r0);
      end
      i_state = 3'b010;
      do_req("resume_k2", 4'b0011, 1'b0, 200, 0, 3);
      clear_history();
      push_src(40);
      do_req("stop_k0", 4'b0011, 1'b0, 0, 1, 1);
      do_req("stop_k1", 4'b0011, 1'b0, 10, 0, 3);
   endtask

   task automatic test_abort();
      int r0;
      int o0;
      int n;
      clear_history();
      push_src(8);
      do_req("abort_setup", 4'b0011, 1'b0, 0, 1, 1);
      o0 = out_cnt;
      pulse_request(4'b0011, 1'b0);
      repeat (5) @(negedge i_clk);
      i_state = 3'b000;
      repeat (30) @(negedge i_clk);
      checks++;
      if (out_cnt != o0) begin
         errors++;
         $display("FAIL abort_div: got %0d outputs expected 0", out_cnt - o0);
      end

      clear_history();
      push_src(10);
      do_req("late_a", 4'b0001, 1'b0, 0, 1, 1);
      do_req("late_b", 4'b0001, 1'b0, 5, 0, 3);
      sram_auto = 1'b0;
      r0 = req_cnt;
      o0 = out_cnt;
      pulse_request(4'b0001, 1'b0);
      n = 0;
      while (req_cnt == r0 && n < 10) begin
         @(negedge i_clk);
         n++;
      end
      checks++;
      if (req_cnt == r0) begin
         errors++;
         $display("FAIL abort_wait_fetch: got 0 fetch pulses expected 1");
      end
      @(negedge i_clk);
      i_state = 3'b011;
      repeat (2) @(negedge i_clk);
      i_data = 16'd999;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      i_data_valid = 1'b0;
      i_state = 3'b010;
      @(negedge i_clk);
      i_data = 16'd777;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      i_data_valid = 1'b0;
      repeat (5) @(negedge i_clk);
      checks++;
      if (out_cnt != o0) begin
         errors++;
         $display("FAIL abort_wait_output: got %0d outputs expected 0", out_cnt - o0);
      end
      sram_auto = 1'b1;
      push_src(20);
      do_req("late_c", 4'b0001, 1'b0, 10, 1, 1);
      do_req("late_d", 4'b0001, 1'b0, 15, 0, 3);
   endtask

   task automatic test_reset_mid();
      int n;
      sram_auto = 1'b0;
      pulse_request(4'b0000, 1'b0);
      n = 0;
      while (o_request_data !== 1'b1 && n < 10) begin
         @(negedge i_clk);
         n++;
      end
      checks++;
      if (o_request_data !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_fetch: o_request_data=%b expected 1", o_request_data);
      end
      #1;
      i_rst = 1'b0;
      #1;
      checks++;
      if (o_data !== 16'd0 || o_valid !== 1'b0 || o_request_data !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: data=%0d valid=%b req=%b expected 0 0 0", o_data, o_valid, o_request_data);
      end
      @(negedge i_clk);
      i_rst = 1'b1;
      sram_auto = 1'b1;
      src_q.delete();
      push_src(30);
      do_req("after_reset", 4'b0011, 1'b0, 0, 1, 1);
   endtask

   initial begin
      test_reset();
      test_x1();
      test_fast();
      test_slow_interp();
      test_slow_hold();
      test_pause_stop();
      test_abort();
      test_reset_mid();
      repeat (5) @(negedge i_clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected outputs never seen, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
